uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader_pkg.sv | 25 ++
 rtl/uart_loader_timer.sv | 32 +++
 rtl/uart_loader.sv | 168 ++++++++++++++++
 tb/tb_uart_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encoding, frame
// constants, abort cause codes and the running checksum helper.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_CHK  = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_CHKSUM  = 2'b10;
  localparam logic [1:0] ERR_ZLEN    = 2'b11;

  // Modulo-256 frame checksum accumulation.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/uart_loader_timer.sv
// Inter-byte idle timer: counts cycles while running, cleared by every byte.
// expire flags the cycle whose edge brings the count to TIMEOUT-1.
module uart_loader_timer #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TERM_CNT = CW'(TIMEOUT - 2);
  localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] count_r;

  // Idle-cycle counter; held at zero outside a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear || !run) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + ONE_CNT;
    end
  end

  assign expire = run && (count_r == TERM_CNT);

endmodule

// File: rtl/uart_loader.sv
// UART program loader: parses SYNC/LEN/words/CHK frames from a byte stream,
// writes 16-bit words to program memory and holds the CPU while loading.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_dat,
  input  logic              rx_dat_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W-1:0] ONE_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic [7:0]        rem_r, rem_s;
  logic [7:0]        sum_r, sum_s;
  logic [7:0]        hi_r, hi_s;
  logic [ADDR_W-1:0] idx_r, idx_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [15:0]       mem_wdata_r, mem_wdata_s;
  logic              mem_we_r, mem_we_s;
  logic              cpu_hold_r;
  logic              done_r, done_s;
  logic              err_r, err_s;
  logic [1:0]        err_code_r, err_code_s;
  logic              expire_s;

  uart_loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_dat_en),
    .run    (state_r != S_IDLE),
    .expire (expire_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath decode; a byte strobe always beats the timeout.
  always_comb begin
    state_s     = state_r;
    rem_s       = rem_r;
    sum_s       = sum_r;
    hi_s        = hi_r;
    idx_s       = idx_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    mem_we_s    = 1'b0;
    done_s      = 1'b0;
    err_s       = 1'b0;
    err_code_s  = err_code_r;
    if (rx_dat_en) begin
      case (state_r)
        S_IDLE: begin
          if (rx_dat == SYNC_BYTE) begin
            state_s    = S_LEN;
            err_code_s = ERR_NONE;
            idx_s      = '0;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_LEN: begin
          if (rx_dat == 8'h00) begin
            state_s    = S_IDLE;
            err_s      = 1'b1;
            err_code_s = ERR_ZLEN;
          end else begin
            state_s = S_HI;
            rem_s   = rx_dat;
            sum_s   = rx_dat;
          end
        end
        S_HI: begin
          hi_s    = rx_dat;
          sum_s   = csum_add(sum_r, rx_dat);
          state_s = S_LO;
        end
        S_LO: begin
          mem_wdata_s = {hi_r, rx_dat};
          mem_addr_s  = idx_r;
          mem_we_s    = 1'b1;
          sum_s       = csum_add(sum_r, rx_dat);
          idx_s       = idx_r + ONE_ADDR;
          rem_s       = rem_r - 8'd1;
          if (rem_r == 8'd1) begin
            state_s = S_CHK;
          end else begin
            state_s = S_HI;
          end
        end
        S_CHK: begin
          state_s = S_IDLE;
          if (rx_dat == sum_r) begin
            done_s = 1'b1;
          end else begin
            err_s      = 1'b1;
            err_code_s = ERR_CHKSUM;
          end
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end else if (expire_s) begin
      state_s    = S_IDLE;
      err_s      = 1'b1;
      err_code_s = ERR_TIMEOUT;
    end else begin
      state_s = state_r;
    end
  end

  // Registered datapath and outputs; cpu_hold tracks the next state so it
  // drops on the same edge that raises done or err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_r       <= 8'h00;
      sum_r       <= 8'h00;
      hi_r        <= 8'h00;
      idx_r       <= '0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 16'h0000;
      mem_we_r    <= 1'b0;
      cpu_hold_r  <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_code_r  <= ERR_NONE;
    end else begin
      rem_r       <= rem_s;
      sum_r       <= sum_s;
      hi_r        <= hi_s;
      idx_r       <= idx_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      mem_we_r    <= mem_we_s;
      cpu_hold_r  <= (state_s != S_IDLE);
      done_r      <= done_s;
      err_r       <= err_s;
      err_code_r  <= err_code_s;
    end
  end

  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;
  assign cpu_hold  = cpu_hold_r;
  assign done      = done_r;
  assign err       = err_r;
  assign err_code  = err_code_r;

endmodule

// File: tb/tb_uart_loader.sv
// Directed scoreboard bench for uart_loader: expected writes and done/err
// events are queued as frames are driven and checked when the DUT emits them.
module tb_uart_loader;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 20;

  logic              clk;
  logic              reset;
  logic [7:0]        rx_dat;
  logic              rx_dat_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  int tests = 0;
  int fails = 0;
  int hold_cnt = 0;

  logic [23:0] wr_q[$];
  logic [2:0]  ev_q[$];

  uart_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_dat    (rx_dat),
    .rx_dat_en (rx_dat_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop expected write / event whenever the DUT produces one.
  always @(negedge clk) begin
    logic [23:0] exp_w;
    logic [2:0]  exp_e;
    if (cpu_hold) hold_cnt++;
    if (mem_we) begin
      exp_w = 'x;
      if (wr_q.size() > 0) exp_w = wr_q.pop_front();
      chk("write", {8'h00, mem_addr, mem_wdata}, {8'h00, exp_w});
      chk("we_under_hold", {31'd0, cpu_hold}, 32'd1);
    end
    if (done || err) begin
      exp_e = 'x;
      if (ev_q.size() > 0) exp_e = ev_q.pop_front();
      chk("event", {29'd0, (done ? 3'b100 : {1'b0, err_code})}, {29'd0, exp_e});
      chk("done_err_excl", {31'd0, done & err}, 32'd0);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_dat    = b;
    rx_dat_en = 1'b1;
    @(negedge clk);
    rx_dat_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(output int steps);
    steps = -1;
    for (int i = 0; i < 200; i++) begin
      if (done || err) begin
        steps = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  {24'd0, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, mem_wdata}, 32'd0);
    chk({tag, "_we"},    {31'd0, mem_we}, 32'd0);
    chk({tag, "_hold"},  {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_err"},   {31'd0, err}, 32'd0);
    chk({tag, "_code"},  {30'd0, err_code}, 32'd0);
  endtask

  initial begin
    int n;
    int h0;
    reset     = 1'b1;
    rx_dat    = 8'h00;
    rx_dat_en = 1'b0;
    idle(3);
    chk_reset_vals("rst");
    reset = 1'b0;
    idle(2);

    // Good two-word frame
    wr_q.push_back({8'h00, 16'h1234});
    wr_q.push_back({8'h01, 16'h5678});
    ev_q.push_back(3'b100);
    send(8'hA5);
    chk("a_hold_in_frame", {31'd0, cpu_hold}, 32'd1);
    send(8'h02); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h16);
    wait_pulse(n);
    chk("a_seen", {31'd0, n >= 0}, 32'd1);
    chk("a_done", {31'd0, done}, 32'd1);
    chk("a_hold_low", {31'd0, cpu_hold}, 32'd0);
    idle(1);
    chk("a_wdata_held", {16'd0, mem_wdata}, 32'h5678);
    chk("a_addr_held", {24'd0, mem_addr}, 32'd1);

    // Same frame, bad checksum
    wr_q.push_back({8'h00, 16'h1234});
    wr_q.push_back({8'h01, 16'h5678});
    ev_q.push_back({1'b0, 2'b10});
    send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h17);
    wait_pulse(n);
    chk("b_err", {31'd0, err}, 32'd1);
    chk("b_code", {30'd0, err_code}, 32'd2);
    idle(3);
    chk("b_code_held", {30'd0, err_code}, 32'd2);

    // Zero length
    ev_q.push_back({1'b0, 2'b11});
    h0 = hold_cnt;
    send(8'hA5); send(8'h00);
    wait_pulse(n);
    chk("c_err", {31'd0, err}, 32'd1);
    chk("c_code", {30'd0, err_code}, 32'd3);
    idle(2);
    chk("c_hold_cycles", hold_cnt - h0, 32'd2);

    // Timeout after the HI byte
    ev_q.push_back({1'b0, 2'b01});
    send(8'hA5); send(8'h01); send(8'h12);
    wait_pulse(n);
    chk("d_latency", n, TIMEOUT - 1);
    chk("d_code", {30'd0, err_code}, 32'd1);
    chk("d_hold_low", {31'd0, cpu_hold}, 32'd0);
    idle(2);

    // Byte arriving on the terminal-count cycle wins
    wr_q.push_back({8'h00, 16'h1234});
    ev_q.push_back(3'b100);
    send(8'hA5); send(8'h01);
    idle(TIMEOUT - 3);
    send(8'h12); send(8'h34); send(8'h47);
    wait_pulse(n);
    chk("e_done", {31'd0, done}, 32'd1);
    idle(2);

    // Noise before SYNC
    wr_q.push_back({8'h00, 16'hABCD});
    ev_q.push_back(3'b100);
    send(8'h00); send(8'hFF); send(8'h5A);
    chk("f_noise_idle", {31'd0, cpu_hold}, 32'd0);
    send(8'hA5); send(8'h01); send(8'hAB); send(8'hCD); send(8'h79);
    wait_pulse(n);
    chk("f_done", {31'd0, done}, 32'd1);
    idle(2);

    // Reset between HI and LO, then a good frame from address 0
    send(8'hA5); send(8'h01); send(8'h12);
    reset = 1'b1;
    #1;
    chk_reset_vals("g_rst");
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    wr_q.push_back({8'h00, 16'hCAFE});
    ev_q.push_back(3'b100);
    send(8'hA5); send(8'h01); send(8'hCA); send(8'hFE); send(8'hC9);
    wait_pulse(n);
    chk("g_done", {31'd0, done}, 32'd1);

    idle(5);
    chk("wr_q_empty", wr_q.size(), 32'd0);
    chk("ev_q_empty", ev_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
